rhd_spi_master: RTL and testbench

SPI master for RHD-style headstages. Drives CS, SCLK and MOSI, and shifts out one 16-bit command per frame. On each frame it captures two 16-bit result words from MISO in double-data-rate fashion: word A is sampled on SCLK rising edges and word B on falling edges. MISO sampling is shifted by a programmable cable delay. The block sits between the acquisition sequencer and the headstage (or the headstage simulation model) and returns both words to the sequencer per frame.

---
 rtl/rhd_spi_master.sv | 146 ++++++++++++++
 tb/tb_rhd_spi_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rhd_spi_master.sv
`timescale 1ns/1ps
// rhd_spi_master: SPI master for RHD headstages; 16-bit command out, DDR capture of two 16-bit words.
// Define RHD_MISO_SYNC_EN to pass MISO through a two-flop synchronizer (sample delay becomes d+2).
module rhd_spi_master #(
    parameter int HALF   = 2,
    parameter int CS_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic [3:0]  cable_delay,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        rsp_valid,
    output logic [15:0] rsp_a,
    output logic [15:0] rsp_b,
    output logic        busy
);
`ifdef RHD_MISO_SYNC_EN
    localparam int SD = 2;
    logic [1:0] ms_q;
    logic       miso_s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ms_q <= '0;
        else ms_q <= {ms_q[0], MISO};
    assign miso_s = ms_q[1];
`else
    localparam int SD = 0;
    logic miso_s;
    assign miso_s = MISO;
`endif
    localparam int IW   = $clog2(16 + SD);
    localparam int TGAP = 34 * HALF - 2 + CS_GAP;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DRAIN, GAP} state_t;
    state_t        state_q;
    logic [7:0]    hc_q;
    logic [3:0]    bc_q, d_q;
    logic [15:0]   sh_q, t_q, a_q, b_q, rsp_a_q, rsp_b_q;
    logic [5:0]    sc_q;
    logic          rs_q, fs_q, cs_q, sclk_q, mosi_q, rv_q;
    logic [14+SD:0] rl_q, fl_q;
    logic [15+SD:0] r_line, f_line;
    logic [IW-1:0] ti;
    logic          hc_end, tap_r, tap_f, done, leave;

    // Strobes fire with each SCLK edge; the tap picks how many cycles later MISO is sampled.
    assign r_line = {rl_q, rs_q};
    assign f_line = {fl_q, fs_q};
    assign ti     = IW'(d_q) + IW'(SD);
    assign tap_r  = r_line[ti];
    assign tap_f  = f_line[ti];
    assign hc_end = hc_q == 8'(HALF - 1);
    assign done   = sc_q == 6'd32 || (sc_q == 6'd31 && (tap_r || tap_f));
    assign leave  = done && t_q >= 16'(TGAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hc_q    <= '0;
            bc_q    <= '0;
            d_q     <= '0;
            sh_q    <= '0;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
            sc_q    <= '0;
            rs_q    <= 1'b0;
            fs_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rv_q    <= 1'b0;
            rl_q    <= '0;
            fl_q    <= '0;
        end else begin
            rs_q <= 1'b0;
            fs_q <= 1'b0;
            rv_q <= 1'b0;
            rl_q <= {rl_q[13+SD:0], rs_q};
            fl_q <= {fl_q[13+SD:0], fs_q};
            hc_q <= hc_end ? 8'd0 : hc_q + 8'd1;
            t_q  <= t_q + 16'd1;
            if (tap_r) a_q <= {a_q[14:0], miso_s};
            if (tap_f) b_q <= {b_q[14:0], miso_s};
            if (tap_r || tap_f) sc_q <= sc_q + 6'd1;
            if (tap_f && sc_q == 6'd31) begin
                rsp_a_q <= a_q;
                rsp_b_q <= {b_q[14:0], miso_s};
                rv_q    <= 1'b1;
            end
            case (state_q)
                IDLE: if (cmd_valid) begin
                    state_q <= LEAD;
                    cs_q    <= 1'b0;
                    mosi_q  <= cmd_word[15];
                    sh_q    <= cmd_word;
                    d_q     <= cable_delay;
                    hc_q    <= 8'd0;
                    t_q     <= 16'd0;
                    sc_q    <= 6'd0;
                    bc_q    <= 4'd0;
                end
                LEAD: if (hc_end) begin
                    state_q <= SHIFT;
                    sclk_q  <= 1'b1;
                    rs_q    <= 1'b1;
                end
                SHIFT: if (hc_end) begin
                    if (sclk_q) begin
                        sclk_q <= 1'b0;
                        fs_q   <= 1'b1;
                        mosi_q <= sh_q[14];
                        sh_q   <= {sh_q[14:0], 1'b0};
                    end else if (bc_q == 4'd15) begin
                        state_q <= TRAIL;
                    end else begin
                        sclk_q <= 1'b1;
                        rs_q   <= 1'b1;
                        bc_q   <= bc_q + 4'd1;
                    end
                end
                TRAIL: if (hc_end) begin
                    cs_q    <= 1'b1;
                    state_q <= leave ? IDLE : done ? GAP : DRAIN;
                end
                default: state_q <= leave ? IDLE : done ? GAP : state_q;
            endcase
        end
    end

    assign cmd_ready = rst_n && state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign CS        = cs_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rv_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
endmodule

// File: tb/tb_rhd_spi_master.sv
`timescale 1ns/1ps
// tb_rhd_spi_master: randomized frames checked against a timing-rule model of the SPI frame and DDR capture.
module tb_rhd_spi_master;
    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, MISO = 1'b0;
    logic [15:0] cmd_word = '0;
    logic [3:0]  cable_delay = '0;
    logic        cmd_ready, CS, SCLK, MOSI, rsp_valid, busy;
    logic [15:0] rsp_a, rsp_b;
    int          n_chk = 0, n_err = 0;
    int          fc = 1000, dm = 0, cs_hi = 0, viol = 0;
    logic        cs_p = 1'b1;
    logic [31:0] cur = '0;
    logic [31:0] mq[$], rq[$];
    int          rc[$], gq[$];
    logic        cs_t[128], sclk_t[128], mosi_t[128], miso_t[128], busy_t[128], rdy_t[128];

    always #5 clk = ~clk;

    rhd_spi_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_word(cmd_word), .cable_delay(cable_delay), .CS(CS), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO), .rsp_valid(rsp_valid), .rsp_a(rsp_a),
        .rsp_b(rsp_b), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Headstage model: A bit around each rising edge (cycles 2+4k, 3+4k), B bit around each falling edge.
    function automatic logic mbit(input int c);
        int j;
        if (c < 2 || c > 65) return 1'b0;
        j = (c - 2) / 2;
        return (j % 2 == 0) ? cur[31 - j / 2] : cur[15 - (j - 1) / 2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!CS && cs_p) begin
            fc = 0;
            gq.push_back(cs_hi);
            cs_hi = 0;
            if (mq.size() > 0) cur = mq.pop_front();
        end else if (fc < 1000) fc++;
        if (CS) cs_hi++;
        cs_p = CS;
        MISO = mbit(fc - dm);
        if (fc < 128) begin
            cs_t[fc] = CS; sclk_t[fc] = SCLK; mosi_t[fc] = MOSI;
            miso_t[fc] = MISO; busy_t[fc] = busy; rdy_t[fc] = cmd_ready;
        end
        if (rsp_valid) begin
            rq.push_back({rsp_a, rsp_b});
            rc.push_back(fc);
        end
        if (rst_n && cmd_ready == busy) viol++;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready && w < 200) begin tick(); w++; end
        chk("ready_wait", 32'(cmd_ready), 1);
    endtask

    task automatic frame(input logic [15:0] cmd, input logic [15:0] a, input logic [15:0] b,
                         input int d, input int m, input bit mid);
        int lo, rises, sm, bl, rr;
        logic [15:0] mo, ea, eb;
        lo = 0; rises = 0; sm = 0; bl = 0; rr = -1; mo = '0; ea = '0; eb = '0;
        mq.push_back({a, b});
        dm = m;
        rq.delete(); rc.delete();
        wait_ready();
        cmd_word = cmd; cable_delay = 4'(d); cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("cs_fall_latency", 32'(fc), 0);
        for (int i = 1; i < 90; i++) begin
            tick();
            if (mid && fc == 30) cable_delay = 4'($urandom);
        end
        for (int c = 0; c < 90; c++) begin
            lo += int'(!cs_t[c]);
            sm += int'(sclk_t[c] != (c >= 2 && c <= 65 && (c - 2) % 4 < 2));
            bl += int'(c < 68 && !busy_t[c]);
            if (c > 0 && sclk_t[c] && !sclk_t[c-1]) begin
                rises++;
                mo = {mo[14:0], mosi_t[c]};
            end
            if (rr < 0 && rdy_t[c]) rr = c;
        end
        for (int k = 0; k < 16; k++) begin
            ea[15-k] = miso_t[2 + 4*k + d];
            eb[15-k] = miso_t[4 + 4*k + d];
        end
        chk("cs_low_cycles", lo, 68);
        chk("cs_high_at_68", 32'(cs_t[68]), 1);
        chk("sclk_wave_errs", sm, 0);
        chk("sclk_rises", rises, 16);
        chk("mosi_word", 32'(mo), 32'(cmd));
        chk("busy_low_in_frame", bl, 0);
        chk("ready_rise", rr, (71 > 65 + d) ? 71 : 65 + d);
        chk("rsp_count", rq.size(), 1);
        if (rq.size() > 0) begin
            chk("rsp_cycle", rc[0], 65 + d);
            chk("rsp_model", rq[0], {ea, eb});
            if (m == d) chk("rsp_words", rq[0], {a, b});
            else if ({a, b} == 32'h12345678) chk("rsp_differs", 32'(rq[0] != {a, b}), 1);
        end
    endtask

    initial begin
        logic [15:0] w[3];
        logic [31:0] pr[3];
        int acc, d;
        cmd_valid = 1'b1;
        cmd_word = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(CS), 1);
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_a", 32'(rsp_a), 0);
        chk("rst_rsp_b", 32'(rsp_b), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        frame(16'hA5C3, 16'h1234, 16'h5678, 0, 0, 1'b0);
        frame(16'($urandom), 16'h1234, 16'h5678, 7, 7, 1'b0);
        frame(16'($urandom), 16'h1234, 16'h5678, 0, 7, 1'b0);
        frame(16'($urandom), 16'h1234, 16'h5678, 7, 7, 1'b1);
        frame(16'($urandom), 16'($urandom), 16'($urandom), 15, 15, 1'b0);
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 15);
            frame(16'($urandom), 16'($urandom), 16'($urandom), d,
                  ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : d, 1'($urandom));
        end

        wait_ready();
        rq.delete(); rc.delete(); gq.delete();
        dm = 0; cable_delay = 4'd0; acc = 0;
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            pr[i] = $urandom;
            mq.push_back(pr[i]);
        end
        cmd_word = w[0];
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                tick();
                if (acc < 3) cmd_word = w[acc];
                else cmd_valid = 1'b0;
            end else tick();
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_frames", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("b2b_gap1", gq[1], 4);
            chk("b2b_gap2", gq[2], 4);
        end
        chk("b2b_rsp_count", rq.size(), 3);
        for (int i = 0; i < 3 && i < rq.size(); i++) chk("b2b_rsp_order", rq[i], pr[i]);

        wait_ready();
        mq.push_back(32'hBEEFCAFE);
        dm = 0; rq.delete(); rc.delete();
        cmd_word = 16'h0F0F; cable_delay = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && fc < 30; i++) tick();
        chk("abort_at_30", fc, 30);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(CS), 1);
        chk("abort_sclk", 32'(SCLK), 0);
        chk("abort_rsp_a", 32'(rsp_a), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("abort_no_rsp", rq.size(), 0);
        frame(16'($urandom), 16'($urandom), 16'($urandom), 3, 3, 1'b0);

        chk("ready_busy_viol", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
